// File: rtl/serial_word_receiver_if.sv
// Byte-in / word-out handshake bundle for serial_word_receiver.
// master: byte producer plus word consumer; slave: the receiver itself.
interface serial_word_receiver_if #(
    parameter int NUM_BYTES = 4
);
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic [8*NUM_BYTES-1:0] word_out;
    logic                   word_valid;
    logic                   word_ready;

    modport master (
        output rx_data, rx_valid, word_ready,
        input  word_out, word_valid
    );

    modport slave (
        input  rx_data, rx_valid, word_ready,
        output word_out, word_valid
    );
endinterface

// File: rtl/serial_word_receiver.sv
// Assembles UART bytes into NUM_BYTES-wide words behind a one-word holding register.
// Optional trailing XOR checksum byte per word: define SERIAL_RX_CHECKSUM_EN.
module serial_word_receiver #(
    parameter int NUM_BYTES      = 4,
    parameter int MSB_FIRST      = 1,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    serial_word_receiver_if.slave bus,
    output logic                 timeout,
    output logic                 overrun,
    output logic [CNT_W-1:0]     overrun_cnt,
    output logic                 chk_err
);
    localparam int W      = 8 * NUM_BYTES;
    localparam int BC_W   = $clog2(NUM_BYTES + 1);
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BC_W-1:0]   LAST_DATA = BC_W'(NUM_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

`ifdef SERIAL_RX_CHECKSUM_EN
    localparam logic [BC_W-1:0] CHK_PHASE = BC_W'(NUM_BYTES);

    function automatic logic [7:0] xor_bytes(input logic [W-1:0] w);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            acc = acc ^ w[8*i +: 8];
        end
        return acc;
    endfunction
`endif

    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [W-1:0]      shift_q, shift_d;
    logic [W-1:0]      word_q, word_d;
    logic              valid_q, valid_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_q, timeout_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              chk_q, chk_d;
    logic [W-1:0]      shift_in_s;
    logic [W-1:0]      commit_word_s;
    logic              commit_s;

    // Shift register contents after accepting the byte currently on rx_data.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shift_in_s = {shift_q[W-9:0], bus.rx_data};
        end else begin
            shift_in_s = {bus.rx_data, shift_q[W-1:8]};
        end
    end

    // Next-state: byte accept, completion/overrun, inter-byte timeout, flush.
    always_comb begin
        byte_cnt_d    = byte_cnt_q;
        shift_d       = shift_q;
        word_d        = word_q;
        valid_d       = valid_q;
        idle_d        = idle_q;
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;
        overrun_d     = 1'b0;
        chk_d         = 1'b0;
        commit_s      = 1'b0;
        commit_word_s = shift_in_s;
        if (clear) begin
            byte_cnt_d = '0;
            valid_d    = 1'b0;
            idle_d     = '0;
        end else begin
            if (valid_q && bus.word_ready) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
            if (bus.rx_valid) begin
                idle_d = '0;
`ifdef SERIAL_RX_CHECKSUM_EN
                if (byte_cnt_q == CHK_PHASE) begin
                    byte_cnt_d = '0;
                    if (bus.rx_data == xor_bytes(shift_q)) begin
                        commit_s      = 1'b1;
                        commit_word_s = shift_q;
                    end else begin
                        chk_d = 1'b1;
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q + BC_W'(1);
                    shift_d    = shift_in_s;
                end
`else
                shift_d = shift_in_s;
                if (byte_cnt_q == LAST_DATA) begin
                    byte_cnt_d = '0;
                    commit_s   = 1'b1;
                end else begin
                    byte_cnt_d = byte_cnt_q + BC_W'(1);
                end
`endif
            end else if ((TIMEOUT_CYCLES > 0) && (byte_cnt_q != '0)) begin
                if (idle_q == IDLE_LAST) begin
                    byte_cnt_d = '0;
                    idle_d     = '0;
                    timeout_d  = 1'b1;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end else begin
                idle_d = '0;
            end
            // A completed word either takes the (free) holding register or is dropped.
            if (commit_s) begin
                if (!valid_q || bus.word_ready) begin
                    word_d  = commit_word_s;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end else begin
                word_d = word_q;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            idle_q     <= '0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            cnt_q      <= '0;
            chk_q      <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            idle_q     <= idle_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            cnt_q      <= cnt_d;
            chk_q      <= chk_d;
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = valid_q;
    assign timeout        = timeout_q;
    assign overrun        = overrun_q;
    assign overrun_cnt    = cnt_q;
    assign chk_err        = chk_q;
endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench: two receiver configurations against an arithmetic word model.
module tb_serial_word_receiver;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear_a, clear_b;
    logic       timeout_a, overrun_a, chk_err_a;
    logic [1:0] cnt_a;
    logic       timeout_b, overrun_b, chk_err_b;
    logic [7:0] cnt_b;
    int passes = 0;
    int fails  = 0;
    int total  = 0;

    serial_word_receiver_if #(.NUM_BYTES(4)) a_if ();
    serial_word_receiver_if #(.NUM_BYTES(8)) b_if ();

    serial_word_receiver #(.NUM_BYTES(4), .MSB_FIRST(1), .TIMEOUT_CYCLES(10), .CNT_W(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .clear(clear_a), .bus(a_if.slave),
        .timeout(timeout_a), .overrun(overrun_a), .overrun_cnt(cnt_a), .chk_err(chk_err_a)
    );

    serial_word_receiver #(.NUM_BYTES(8), .MSB_FIRST(0), .TIMEOUT_CYCLES(0), .CNT_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(clear_b), .bus(b_if.slave),
        .timeout(timeout_b), .overrun(overrun_b), .overrun_cnt(cnt_b), .chk_err(chk_err_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word value from the byte sequence: byte i carries weight 256^position.
    function automatic logic [63:0] model_word(input logic [7:0] bs[8], input int nb, input bit msb_first);
        logic [63:0] w;
        w = 64'd0;
        for (int i = 0; i < nb; i++) begin
            int pos;
            pos = msb_first ? (nb - 1 - i) : i;
            w = w + (64'(bs[i]) << (8 * pos));
        end
        return w;
    endfunction

    function automatic logic [7:0] model_xor(input logic [7:0] bs[8], input int nb);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < nb; i++) x = x ^ bs[i];
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_byte(input logic [7:0] b);
        a_if.rx_data  = b;
        a_if.rx_valid = 1'b1;
        tick();
        a_if.rx_valid = 1'b0;
    endtask

    task automatic b_byte(input logic [7:0] b);
        b_if.rx_data  = b;
        b_if.rx_valid = 1'b1;
        tick();
        b_if.rx_valid = 1'b0;
    endtask

    // Sends one word to A; late_ready raises word_ready together with the committing byte.
    task automatic a_send(input logic [7:0] bs[8], input int gap, input logic [7:0] delta, input bit late_ready);
        for (int i = 0; i < 4; i++) begin
`ifndef SERIAL_RX_CHECKSUM_EN
            if (late_ready && i == 3) a_if.word_ready = 1'b1;
`endif
            a_byte(bs[i]);
            if (i < 3) repeat (gap) tick();
        end
`ifdef SERIAL_RX_CHECKSUM_EN
        repeat (gap) tick();
        if (late_ready) a_if.word_ready = 1'b1;
        a_byte(model_xor(bs, 4) ^ delta);
`endif
    endtask

    task automatic b_send(input logic [7:0] bs[8], input int gap);
        for (int i = 0; i < 8; i++) begin
            b_byte(bs[i]);
            if (i < 7) repeat (gap) tick();
        end
`ifdef SERIAL_RX_CHECKSUM_EN
        b_byte(model_xor(bs, 8));
`endif
    endtask

    initial begin
        logic [7:0]  bs[8];
        logic [7:0]  ys[8];
        logic [63:0] exp_w;
        reset_n = 1'b1;
        clear_a = 1'b0; clear_b = 1'b0;
        a_if.rx_data = 8'h00; a_if.rx_valid = 1'b0; a_if.word_ready = 1'b1;
        b_if.rx_data = 8'h00; b_if.rx_valid = 1'b0; b_if.word_ready = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("rst_a_word", a_if.word_out, 64'h0);
        check("rst_a_valid", a_if.word_valid, 64'h0);
        check("rst_a_flags", {timeout_a, overrun_a, chk_err_a, cnt_a}, 64'h0);
        check("rst_b_word", b_if.word_out, 64'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Basic MSB-first word, valid for exactly one cycle.
        bs = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00};
        a_send(bs, 0, 8'h00, 1'b0);
        check("basic_word", a_if.word_out, 64'h12345678);
        check("basic_valid", a_if.word_valid, 64'h1);
        tick();
        check("basic_valid_drop", a_if.word_valid, 64'h0);

        // LSB-first, 8-byte word.
        bs = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        b_send(bs, 0);
        check("lsb_word", b_if.word_out, 64'h0807060504030201);
        check("lsb_valid", b_if.word_valid, 64'h1);

        // Randomized words with short gaps on A.
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 8; i++) bs[i] = 8'($urandom_range(0, 255));
            a_send(bs, int'($urandom_range(0, 3)), 8'h00, 1'b0);
            check("rand_a_word", a_if.word_out, model_word(bs, 4, 1'b1));
            check("rand_a_valid", a_if.word_valid, 64'h1);
        end

        // Randomized words on B, including long idles (timeout disabled).
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 8; i++) bs[i] = 8'($urandom_range(0, 255));
            b_send(bs, (n == 0) ? 40 : int'($urandom_range(0, 2)));
            check("rand_b_word", b_if.word_out, model_word(bs, 8, 1'b0));
            check("rand_b_timeout", timeout_b, 64'h0);
        end

        // Overrun: second word dropped, first one held.
        tick();
        a_if.word_ready = 1'b0;
        bs = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00, 8'h00, 8'h00};
        a_send(bs, 0, 8'h00, 1'b0);
        check("ovr_first", a_if.word_out, 64'hAABBCCDD);
        bs = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        a_send(bs, 1, 8'h00, 1'b0);
        check("ovr_pulse", overrun_a, 64'h1);
        check("ovr_cnt", cnt_a, 64'h1);
        check("ovr_hold", a_if.word_out, 64'hAABBCCDD);
        tick();
        check("ovr_pulse_end", overrun_a, 64'h0);
        a_if.word_ready = 1'b1;
        tick();
        check("ovr_consumed", a_if.word_valid, 64'h0);

        // Complete and consume on the same edge: new word loads, no overrun.
        a_if.word_ready = 1'b0;
        for (int i = 0; i < 8; i++) bs[i] = 8'($urandom_range(0, 255));
        a_send(bs, 0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) ys[i] = 8'($urandom_range(0, 255));
        a_send(ys, 0, 8'h00, 1'b1);
        a_if.word_ready = 1'b0;
        exp_w = model_word(ys, 4, 1'b1);
        check("swap_word", a_if.word_out, exp_w);
        check("swap_valid", a_if.word_valid, 64'h1);
        check("swap_no_ovr", {overrun_a, cnt_a}, 64'h1);

        // Saturating overrun count (CNT_W=2 saturates at 3).
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 8; i++) bs[i] = 8'($urandom_range(0, 255));
            a_send(bs, 0, 8'h00, 1'b0);
        end
        check("sat_pulse", overrun_a, 64'h1);
        check("sat_cnt", cnt_a, 64'h3);
        check("sat_hold", a_if.word_out, exp_w);
        a_if.word_ready = 1'b1;
        tick();

        // Timeout after 10 idle cycles inside a partial word.
        a_byte(8'hDE);
        a_byte(8'hAD);
        repeat (9) tick();
        check("to_early", timeout_a, 64'h0);
        tick();
        check("to_pulse", timeout_a, 64'h1);
        check("to_no_word", a_if.word_valid, 64'h0);
        tick();
        check("to_pulse_end", timeout_a, 64'h0);
        bs = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        a_send(bs, 0, 8'h00, 1'b0);
        check("to_resync", a_if.word_out, 64'h01020304);

        // A byte on the would-timeout cycle wins.
        bs = '{8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h00, 8'h00, 8'h00, 8'h00};
        a_byte(bs[0]);
        a_byte(bs[1]);
        repeat (9) tick();
        a_byte(bs[2]);
        check("to_byte_wins", timeout_a, 64'h0);
        a_byte(bs[3]);
`ifdef SERIAL_RX_CHECKSUM_EN
        a_byte(model_xor(bs, 4));
`endif
        check("to_byte_word", a_if.word_out, 64'h5A5B5C5D);

        // Clear discards the partial word and the byte presented with it.
        a_byte(8'h11);
        a_byte(8'h22);
        clear_a = 1'b1;
        a_byte(8'h99);
        clear_a = 1'b0;
        bs = '{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h00, 8'h00, 8'h00, 8'h00};
        a_send(bs, 0, 8'h00, 1'b0);
        check("clr_word", a_if.word_out, 64'hCAFEBABE);
        a_if.word_ready = 1'b0;
        a_send(bs, 0, 8'h00, 1'b0);
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        check("clr_valid", a_if.word_valid, 64'h0);
        check("clr_keeps_cnt", cnt_a, 64'h3);

        // Asynchronous reset mid-word while a word is held.
        for (int i = 0; i < 8; i++) bs[i] = 8'($urandom_range(0, 255));
        a_send(bs, 0, 8'h00, 1'b0);
        a_byte(8'h77);
        a_byte(8'h66);
        #3 reset_n = 1'b0;
        #1;
        check("arst_word", a_if.word_out, 64'h0);
        check("arst_valid", a_if.word_valid, 64'h0);
        check("arst_cnt", cnt_a, 64'h0);
        tick();
        reset_n = 1'b1;
        a_if.word_ready = 1'b1;
        for (int i = 0; i < 8; i++) bs[i] = 8'($urandom_range(0, 255));
        a_send(bs, 0, 8'h00, 1'b0);
        check("arst_after_word", a_if.word_out, model_word(bs, 4, 1'b1));

`ifdef SERIAL_RX_CHECKSUM_EN
        // Checksum match and mismatch.
        tick();
        bs = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00};
        a_send(bs, 0, 8'h00, 1'b0);
        check("chk_ok_word", a_if.word_out, 64'h12345678);
        check("chk_ok_err", chk_err_a, 64'h0);
        tick();
        a_send(bs, 0, 8'h01, 1'b0);
        check("chk_bad_err", chk_err_a, 64'h1);
        check("chk_bad_valid", a_if.word_valid, 64'h0);
        check("chk_bad_no_ovr", overrun_a, 64'h0);
        tick();
        check("chk_err_end", chk_err_a, 64'h0);
`else
        check("chk_tied_a", chk_err_a, 64'h0);
        check("chk_tied_b", chk_err_b, 64'h0);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
Parametrised successor to the fixed 4-byte nonce receive buffer. It assembles a stream of bytes from a UART deserializer into NUM_BYTES-wide words and presents them on a valid/ready output with a one-word holding register. Byte order is configurable, a stalled partial word is resynchronised by an inter-byte timeout, and dropped words are counted. It sits between async_receiver and the hub/miner logic; the same block serves nonce returns from slaves and work or midstate loads on miners.

Parameters:
NUM_BYTES, 4, bytes per word (≥2); word width W = 8*NUM_BYTES.
MSB_FIRST, 1, 1: first received byte lands in word_out[W-1:W-8]; 0: first byte lands in word_out[7:0].
TIMEOUT_CYCLES, 50000, idle clk cycles allowed inside a partial word before it is discarded; 0 disables the timeout.
CNT_W, 8, width of overrun_cnt.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
clear  input  1  synchronous flush of the partial word and the holding register.
rx_data  input  8  byte from the deserializer.
rx_valid  input  1  one-cycle strobe: rx_data is valid.
word_out  output  W  assembled word.
word_valid  output  1  word_out holds an unconsumed word.
word_ready  input  1  consumer accepts word_out when high together with word_valid.
timeout  output  1  one-cycle pulse: partial word discarded on timeout.
overrun  output  1  one-cycle pulse: completed word dropped because the holding register was full.
overrun_cnt  output  CNT_W  saturating count of overrun events.
chk_err  output  1  one-cycle pulse on checksum mismatch; constant 0 without the optional feature.

Behaviour:
- Reset (reset_n low, asynchronous): byte_cnt=0, shift register=0, word_out=0, word_valid=0, timeout=0, overrun=0, overrun_cnt=0, chk_err=0, idle counter=0.
- States are implied by byte_cnt in 0..NUM_BYTES-1 (plus the checksum phase when the feature is enabled).
  - IDLE: byte_cnt=0.
  - COLLECT: byte_cnt>0.
- Byte accept: every cycle with rx_valid=1 (and clear=0) accepts one byte.
  - MSB_FIRST=1: shift = {shift[W-9:0], rx_data}.
  - MSB_FIRST=0: shift = {rx_data, shift[W-1:8]}.
  - byte_cnt increments.
- Completion: the edge that accepts byte NUM_BYTES wraps byte_cnt to 0 and loads the completed word, including the new byte, directly into word_out. word_valid is set on that same edge, so word_valid rises at the edge after the final rx_valid cycle. Latency is 1 cycle; there is no separate copy state.
- Holding register: it is free if word_valid=0, or if word_valid=1 and word_ready=1 in the same cycle.
  - Complete and consume in the same cycle: the new word is loaded and word_valid stays 1.
  - Consume only: word_valid is cleared at the edge.
  - word_out must not change while word_valid=1 and word_ready=0.
- Overrun: completion while the holding register is not free.
  - The new word is dropped and the old word is kept.
  - overrun pulses for 1 cycle.
  - overrun_cnt increments and saturates at 2^CNT_W-1.
  - byte_cnt still returns to 0.
- Timeout (TIMEOUT_CYCLES>0):
  - The idle counter runs only while byte_cnt≠0 and rx_valid=0.
  - It is zeroed on every accepted byte and whenever byte_cnt=0.
  - On the cycle the counter would reach TIMEOUT_CYCLES: byte_cnt←0, the partial word is discarded, and timeout pulses for 1 cycle. The holding register is unaffected.
  - If rx_valid arrives on that same cycle, the byte wins: it is accepted as a normal byte and there is no timeout.
- clear=1: byte_cnt←0, word_valid←0, idle counter←0.
  - Any rx_valid in that cycle is ignored.
  - overrun_cnt is retained; only reset_n zeroes it.
- Bytes arriving back-to-back on consecutive cycles must all be accepted.

Optional Feature:
Macro SERIAL_RX_CHECKSUM_EN.
- Defined: each word is followed by one checksum byte equal to the XOR of its NUM_BYTES data bytes.
  - After data byte NUM_BYTES, the block waits for the checksum byte. The timeout still applies during this wait.
  - On match: the word is committed, at the edge that accepts the checksum byte, under the same holding and overrun rules.
  - On mismatch: the word is discarded, chk_err pulses for 1 cycle, and there is no overrun.
- Undefined: no checksum byte is expected, and chk_err is tied to 0.

Test Plan:
- Basic word, MSB_FIRST=1, NUM_BYTES=4, word_ready=1: bytes 0x12,0x34,0x56,0x78 → word_out=0x12345678, word_valid high exactly 1 cycle, starting the edge after the 0x78 strobe.
- Byte order and width, MSB_FIRST=0, NUM_BYTES=8: bytes 0x01..0x08 → word_out=0x0807060504030201.
- Overrun: word_ready=0, send 0xAABBCCDD then 0x11223344 → word_out stays 0xAABBCCDD, overrun pulses once, overrun_cnt=1. Then raise word_ready → word_valid drops.
- Timeout, TIMEOUT_CYCLES=10: send 0xDE,0xAD, idle 10 cycles → timeout pulses, no word. Then send 0x01,0x02,0x03,0x04 → word_out=0x01020304.
- Clear and reset: send 2 bytes, pulse clear together with rx_valid of 3rd byte, then 4 bytes 0xCAFEBABE → word_out=0xCAFEBABE. Assert reset_n low mid-word → all outputs 0 immediately, without waiting for a clock edge.
- With SERIAL_RX_CHECKSUM_EN: 0x12,0x34,0x56,0x78,0x08 → word 0x12345678. Same data with checksum 0x09 → chk_err pulse, word_valid stays 0.
